// File: rtl/nap_timer_ctrl.sv
// Nap timer countdown sequencer: captures an M:SS preset from the keypad selector,
// counts it down in BCD at one-second ticks with pause/cancel, then sounds the alarm.
module nap_timer_ctrl #(
   parameter int CLK_DIV   = 1000,
   parameter int ALARM_SEC = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] set_one_sec,
   input  logic [3:0] set_ten_sec,
   input  logic [3:0] set_one_min,
   input  logic       complete_setting,
   input  logic       pause,
   input  logic       cancel,
   output logic       sel_en,
   output logic [3:0] run_min,
   output logic [3:0] run_ten,
   output logic [3:0] run_one,
   output logic       running,
   output logic       alarm,
   output logic       done
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

   typedef enum logic [1:0] {S_SETUP, S_RUN, S_PAUSE, S_ALARM} state_t;

   state_t          state_q, state_n;
   logic [11:0]     preset_q, preset_n;
   logic [11:0]     count_q, count_n;
   logic [PW-1:0]   presc_q, presc_n;
   logic [AW-1:0]   acnt_q, acnt_n;
   logic            done_n;
   logic            tick;
   logic [PW-1:0]   presc_adv;
   logic [11:0]     cap;
   logic [11:0]     dec;

   function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

   // BCD countdown of {min, ten, one}; never called on 0:00 because ALARM takes over there.
   function automatic logic [11:0] bcd_dec(input logic [11:0] c);
      logic [3:0] m, t, o;
      m = c[11:8];
      t = c[7:4];
      o = c[3:0];
      if (o != 4'd0) begin
         o = o - 4'd1;
      end else begin
         o = 4'd9;
         if (t != 4'd0) begin
            t = t - 4'd1;
         end else begin
            t = 4'd5;
            m = m - 4'd1;
         end
      end
      return {m, t, o};
   endfunction

   always_comb begin
      state_n   = state_q;
      preset_n  = preset_q;
      count_n   = count_q;
      presc_n   = presc_q;
      acnt_n    = acnt_q;
      done_n    = 1'b0;
      tick      = (presc_q == PRESC_LAST);
      presc_adv = tick ? '0 : presc_q + 1'b1;
      dec       = bcd_dec(count_q);
      cap       = preset_q;
      if (set_one_min != 4'd0) cap[11:8] = clamp(set_one_min, 4'd9);
      if (set_ten_sec != 4'd0) cap[7:4]  = clamp(set_ten_sec, 4'd5);
      if (set_one_sec != 4'd0) cap[3:0]  = clamp(set_one_sec, 4'd9);

      if (cancel) begin
         state_n  = S_SETUP;
         preset_n = '0;
         count_n  = '0;
         presc_n  = '0;
         acnt_n   = '0;
      end else begin
         case (state_q)
            S_SETUP: begin
               preset_n = cap;
               count_n  = cap;
               if (complete_setting && (cap != 12'h000)) begin
                  state_n = S_RUN;
                  presc_n = '0;
               end
            end
            S_RUN: begin
               if (pause) begin
                  state_n = S_PAUSE;
               end else begin
                  presc_n = presc_adv;
                  if (tick) begin
                     count_n = dec;
                     if (dec == 12'h000) begin
                        state_n = S_ALARM;
                        done_n  = 1'b1;
                        acnt_n  = '0;
                     end
                  end
               end
            end
            S_PAUSE: begin
               if (pause) state_n = S_RUN;
            end
            S_ALARM: begin
               presc_n = presc_adv;
               if (tick) begin
                  if (acnt_q == ALARM_LAST) begin
                     state_n  = S_SETUP;
                     preset_n = '0;
                     count_n  = '0;
                     acnt_n   = '0;
                  end else begin
                     acnt_n = acnt_q + 1'b1;
                  end
               end
            end
            default: state_n = S_SETUP;
         endcase
      end
   end

   // Status flags are flopped from the next state so they line up with the count registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_SETUP;
         preset_q <= '0;
         count_q  <= '0;
         presc_q  <= '0;
         acnt_q   <= '0;
         done     <= 1'b0;
         sel_en   <= 1'b1;
         running  <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         state_q  <= state_n;
         preset_q <= preset_n;
         count_q  <= count_n;
         presc_q  <= presc_n;
         acnt_q   <= acnt_n;
         done     <= done_n;
         sel_en   <= (state_n == S_SETUP);
         running  <= (state_n == S_RUN);
         alarm    <= (state_n == S_ALARM);
      end
   end

   assign run_min = count_q[11:8];
   assign run_ten = count_q[7:4];
   assign run_one = count_q[3:0];

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Directed bench for nap_timer_ctrl (CLK_DIV=4, ALARM_SEC=2): stimulus queues expected
// output snapshots and done pulses; a negedge monitor pops and compares them.
module tb_nap_timer_ctrl;

   logic       clock;
   logic       reset;
   logic [3:0] set_one_sec, set_ten_sec, set_one_min;
   logic       complete_setting, pause, cancel;
   logic       sel_en, running, alarm, done;
   logic [3:0] run_min, run_ten, run_one;

   nap_timer_ctrl #(.CLK_DIV(4), .ALARM_SEC(2)) dut (
      .clock(clock), .reset(reset),
      .set_one_sec(set_one_sec), .set_ten_sec(set_ten_sec), .set_one_min(set_one_min),
      .complete_setting(complete_setting), .pause(pause), .cancel(cancel),
      .sel_en(sel_en), .run_min(run_min), .run_ten(run_ten), .run_one(run_one),
      .running(running), .alarm(alarm), .done(done)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // scoreboard state
   logic [15:0] exp_q[$];
   string       name_q[$];
   logic [11:0] done_q[$];
   int          chk_cnt  = 0;
   int          pass_cnt = 0;

   logic [15:0] m_exp, m_act;
   string       m_name;
   logic [11:0] d_exp;

   function automatic logic [15:0] mk(input bit s, input bit r, input bit a, input bit d,
                                      input logic [3:0] m, input logic [3:0] t,
                                      input logic [3:0] o);
      return {s, r, a, d, m, t, o};
   endfunction

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expect_out(input string nm, input logic [15:0] e);
      name_q.push_back(nm);
      exp_q.push_back(e);
   endtask

   task automatic expect_done();
      done_q.push_back(12'h000);
   endtask

   // monitor
   always @(negedge clock) begin
      while (exp_q.size() > 0) begin
         m_exp  = exp_q.pop_front();
         m_name = name_q.pop_front();
         m_act  = {sel_en, running, alarm, done, run_min, run_ten, run_one};
         chk_cnt++;
         if (m_act === m_exp) pass_cnt++;
         else $display("FAIL %s: got {sel,run,alm,done,m:t:o}=%h expected %h", m_name, m_act, m_exp);
      end
      if (done === 1'b1) begin
         chk_cnt++;
         if (done_q.size() == 0) begin
            $display("FAIL unexpected_done: got done=1 with count %h:%h%h, expected no pulse",
                     run_min, run_ten, run_one);
         end else begin
            d_exp = done_q.pop_front();
            if ({run_min, run_ten, run_one} === d_exp) pass_cnt++;
            else $display("FAIL done_count: got %h expected %h", {run_min, run_ten, run_one}, d_exp);
         end
      end
   end

   initial begin
      reset = 1'b1;
      set_one_sec = 4'd0; set_ten_sec = 4'd0; set_one_min = 4'd0;
      complete_setting = 1'b0; pause = 1'b0; cancel = 1'b0;
      cyc(2);
      expect_out("reset_values", mk(1, 0, 0, 0, 0, 0, 0));
      cyc(1);
      reset = 1'b0;
      cyc(1);

      // 3x s, then 5 s, then start: 0:35 -> 0:34 four cycles after RUN entry
      set_ten_sec = 4'd3; cyc(1); set_ten_sec = 4'd0;
      expect_out("cap_0_30", mk(1, 0, 0, 0, 0, 3, 0));
      set_one_sec = 4'd5; cyc(1); set_one_sec = 4'd0;
      expect_out("cap_0_35", mk(1, 0, 0, 0, 0, 3, 5));
      complete_setting = 1'b1; cyc(1); complete_setting = 1'b0;
      expect_out("run_entry_0_35", mk(0, 1, 0, 0, 0, 3, 5));
      cyc(3);
      expect_out("run_pre_tick", mk(0, 1, 0, 0, 0, 3, 5));
      cyc(1);
      expect_out("run_first_tick", mk(0, 1, 0, 0, 0, 3, 4));
      set_one_min = 4'd7; complete_setting = 1'b1; cyc(1);
      set_one_min = 4'd0; complete_setting = 1'b0;
      expect_out("digits_ignored_run", mk(0, 1, 0, 0, 0, 3, 4));
      cancel = 1'b1; cyc(1); cancel = 1'b0;
      expect_out("cancel_run", mk(1, 0, 0, 0, 0, 0, 0));

      // 1:00 with double borrow, full run to ALARM, pause ignored in ALARM
      set_one_min = 4'd1; cyc(1); set_one_min = 4'd0;
      expect_out("cap_1_00", mk(1, 0, 0, 0, 1, 0, 0));
      complete_setting = 1'b1; cyc(1); complete_setting = 1'b0;
      expect_out("run_1_00", mk(0, 1, 0, 0, 1, 0, 0));
      cyc(4);
      expect_out("double_borrow", mk(0, 1, 0, 0, 0, 5, 9));
      expect_done();
      cyc(232);
      expect_out("run_0_01", mk(0, 1, 0, 0, 0, 0, 1));
      cyc(4);
      expect_out("alarm_entry", mk(0, 0, 1, 1, 0, 0, 0));
      cyc(1);
      expect_out("alarm_done_low", mk(0, 0, 1, 0, 0, 0, 0));
      pause = 1'b1; cyc(1); pause = 1'b0;
      cyc(5);
      expect_out("alarm_last_cycle", mk(0, 0, 1, 0, 0, 0, 0));
      cyc(1);
      expect_out("alarm_to_setup", mk(1, 0, 0, 0, 0, 0, 0));

      // 0:05 with pause at prescaler=2 held 20 cycles
      set_one_sec = 4'd5; cyc(1); set_one_sec = 4'd0;
      complete_setting = 1'b1; cyc(1); complete_setting = 1'b0;
      cyc(2);
      pause = 1'b1; cyc(1); pause = 1'b0;
      expect_out("paused", mk(0, 0, 0, 0, 0, 0, 5));
      cyc(20);
      expect_out("paused_hold", mk(0, 0, 0, 0, 0, 0, 5));
      pause = 1'b1; cyc(1); pause = 1'b0;
      expect_out("resumed", mk(0, 1, 0, 0, 0, 0, 5));
      cyc(1);
      expect_out("resume_pre_tick", mk(0, 1, 0, 0, 0, 0, 5));
      cyc(1);
      expect_out("resume_tick", mk(0, 1, 0, 0, 0, 0, 4));

      // cancel + pause + final tick collide at 0:01
      cyc(15);
      expect_out("pre_cancel_0_01", mk(0, 1, 0, 0, 0, 0, 1));
      cancel = 1'b1; pause = 1'b1; cyc(1); cancel = 1'b0; pause = 1'b0;
      expect_out("cancel_beats_tick", mk(1, 0, 0, 0, 0, 0, 0));
      cyc(2);
      expect_out("cancel_settled", mk(1, 0, 0, 0, 0, 0, 0));

      // zero preset ignored, clamping, cancel in SETUP, capture with complete
      complete_setting = 1'b1; cyc(1); complete_setting = 1'b0;
      expect_out("zero_preset_ignored", mk(1, 0, 0, 0, 0, 0, 0));
      set_one_sec = 4'd12; cyc(1); set_one_sec = 4'd0;
      expect_out("clamp_one_sec", mk(1, 0, 0, 0, 0, 0, 9));
      set_ten_sec = 4'd7; set_one_min = 4'd15; cyc(1);
      set_ten_sec = 4'd0; set_one_min = 4'd0;
      expect_out("clamp_9_59", mk(1, 0, 0, 0, 9, 5, 9));
      cancel = 1'b1; cyc(1); cancel = 1'b0;
      expect_out("cancel_setup", mk(1, 0, 0, 0, 0, 0, 0));
      set_one_sec = 4'd3; complete_setting = 1'b1; cyc(1);
      set_one_sec = 4'd0; complete_setting = 1'b0;
      expect_out("same_cycle_capture", mk(0, 1, 0, 0, 0, 0, 3));
      expect_done();
      cyc(11);
      expect_out("run_0_01_b", mk(0, 1, 0, 0, 0, 0, 1));
      cyc(1);
      expect_out("alarm_entry_b", mk(0, 0, 1, 1, 0, 0, 0));
      cyc(1);

      // asynchronous reset mid-ALARM, sampled before the next rising edge
      #2;
      reset = 1'b1;
      expect_out("async_reset", mk(1, 0, 0, 0, 0, 0, 0));
      cyc(2);
      reset = 1'b0;
      complete_setting = 1'b1; cyc(1); complete_setting = 1'b0;
      expect_out("post_reset_idle", mk(1, 0, 0, 0, 0, 0, 0));

      cyc(1);
      @(negedge clock);
      #1;
      chk_cnt++;
      if (done_q.size() == 0) pass_cnt++;
      else $display("FAIL missing_done: got %0d unmatched expected pulses, required 0", done_q.size());

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
